spi_slave_rx: RTL and testbench



---
 rtl/spi_pkg.sv | 16 +
 rtl/spi_sync_edge.sv | 33 +++
 rtl/spi_slave_rx.sv | 135 +++++++++++++
 tb/tb_spi_slave_rx.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: receive FSM states, default word width and the
// idle line levels used to reset input synchronizers.
package spi_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } spi_state_t;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;

    localparam logic SPI_CLK_IDLE = 1'b1;
    localparam logic CS_IDLE      = 1'b1;
    localparam logic MOSI_IDLE    = 1'b1;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with a trailing flop
// providing single-cycle rise/fall pulses on the synchronized level.
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    // SYNC_STAGES must be at least 2 for metastability settling.
    logic [SYNC_STAGES-1:0] stages;
    logic                   prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stages <= {SYNC_STAGES{RESET_VAL}};
            prev   <= RESET_VAL;
        end else begin
            stages <= {stages[SYNC_STAGES-2:0], din};
            prev   <= stages[SYNC_STAGES-1];
        end
    end

    assign sync = stages[SYNC_STAGES-1];
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI receive stage: re-times spi_clk/cs/mosi into clk, shifts in MSB-first
// words and hands them over on a valid/ready holding register.
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          SAMPLE_FALL = 1'b1,
    parameter bit          LATE_CS     = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  spi_clk,
    input  logic                  cs,
    input  logic                  mosi,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  busy,
    output logic                  frame_err,
    output logic                  overrun
);

    localparam int unsigned CW = $clog2(DATA_WIDTH + 1);

    logic sclk_sync_unused, sclk_rise, sclk_fall;
    logic cs_sync_unused, cs_rise, cs_fall;
    logic mosi_sync, mosi_rise_unused, mosi_fall_unused;
    logic sample;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(SPI_CLK_IDLE)) u_sync_sclk (
        .clk(clk), .reset(reset), .din(spi_clk),
        .sync(sclk_sync_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(CS_IDLE)) u_sync_cs (
        .clk(clk), .reset(reset), .din(cs),
        .sync(cs_sync_unused), .rise(cs_rise), .fall(cs_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(MOSI_IDLE)) u_sync_mosi (
        .clk(clk), .reset(reset), .din(mosi),
        .sync(mosi_sync), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    assign sample = SAMPLE_FALL ? sclk_fall : sclk_rise;

    spi_state_t            state, state_d;
    logic [CW-1:0]         count, count_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] word;
    logic                  word_done;
    logic                  ferr_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            shift_q <= '0;
        end else begin
            state   <= state_d;
            count   <= count_d;
            shift_q <= shift_d;
        end
    end

    // A sample and a cs rise in the same cycle: shift first, then apply the
    // cs rule to the updated count.
    always_comb begin
        state_d   = state;
        count_d   = count;
        shift_d   = shift_q;
        word      = shift_q;
        word_done = 1'b0;
        ferr_d    = 1'b0;
        unique case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_d = SHIFT;
                    count_d = '0;
                    shift_d = '0;
                end
            end
            SHIFT: begin
                if (sample) begin
                    shift_d = {shift_q[DATA_WIDTH-2:0], mosi_sync};
                    count_d = count + 1'b1;
                    if (count_d == CW'(DATA_WIDTH)) begin
                        word_done = 1'b1;
                        word      = shift_d;
                        count_d   = '0;
                    end
                end
                if (cs_rise) begin
                    state_d = IDLE;
                    if (count_d != '0) begin
                        if (LATE_CS && (count_d == CW'(DATA_WIDTH - 1))) begin
                            word_done = 1'b1;
                            word      = {shift_d[DATA_WIDTH-2:0], mosi_sync};
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end
                    count_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state == SHIFT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= ferr_d;
            overrun   <= 1'b0;
            if (word_done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= word;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_rx.sv
// Scoreboard bench for spi_slave_rx: two instances (LATE_CS=0 and 1) share
// one stimulus; expected words/pulses are queued per instance.
module tb_spi_slave_rx;

    localparam logic [1:0] K_WORD = 2'd0;
    localparam logic [1:0] K_FERR = 2'd1;
    localparam logic [1:0] K_OVR  = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] data;
    } ev_t;

    logic       clk;
    logic       reset;
    logic       spi_clk;
    logic       cs;
    logic       mosi;
    logic       rx_ready;
    logic [7:0] rx_data   [2];
    logic       rx_valid  [2];
    logic       busy      [2];
    logic       frame_err [2];
    logic       overrun   [2];

    ev_t q0[$];
    ev_t q1[$];
    int  total = 0;
    int  bad   = 0;

    spi_slave_rx #(.DATA_WIDTH(8), .SYNC_STAGES(2), .SAMPLE_FALL(1'b1), .LATE_CS(1'b0)) dut0 (
        .clk(clk), .reset(reset), .spi_clk(spi_clk), .cs(cs), .mosi(mosi),
        .rx_data(rx_data[0]), .rx_valid(rx_valid[0]), .rx_ready(rx_ready),
        .busy(busy[0]), .frame_err(frame_err[0]), .overrun(overrun[0])
    );

    spi_slave_rx #(.DATA_WIDTH(8), .SYNC_STAGES(2), .SAMPLE_FALL(1'b1), .LATE_CS(1'b1)) dut1 (
        .clk(clk), .reset(reset), .spi_clk(spi_clk), .cs(cs), .mosi(mosi),
        .rx_data(rx_data[1]), .rx_valid(rx_valid[1]), .rx_ready(rx_ready),
        .busy(busy[1]), .frame_err(frame_err[1]), .overrun(overrun[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic sb_check(input int d, input ev_t got);
        ev_t exp;
        total++;
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            bad++;
            $display("FAIL dut%0d unexpected event: got kind=%0d data=%h expected none", d, got.kind, got.data);
        end else begin
            exp = (d == 0) ? q0.pop_front() : q1.pop_front();
            if (got !== exp) begin
                bad++;
                $display("FAIL dut%0d event: got kind=%0d data=%h expected kind=%0d data=%h",
                         d, got.kind, got.data, exp.kind, exp.data);
            end
        end
    endtask

    // Handshakes are judged at negedge; inputs only change just after posedge,
    // so what is seen here is what the next posedge sees.
    always @(negedge clk) begin
        if (!reset) begin
            for (int d = 0; d < 2; d++) begin
                if (frame_err[d])             sb_check(d, '{kind: K_FERR, data: 8'h00});
                if (overrun[d])               sb_check(d, '{kind: K_OVR,  data: 8'h00});
                if (rx_valid[d] && rx_ready)  sb_check(d, '{kind: K_WORD, data: rx_data[d]});
            end
        end
    end

    task automatic expect_ev(input int d, input logic [1:0] k, input logic [7:0] v);
        if (d == 0) q0.push_back('{kind: k, data: v});
        else        q1.push_back('{kind: k, data: v});
    endtask

    task automatic expect_both(input logic [1:0] k, input logic [7:0] v);
        expect_ev(0, k, v);
        expect_ev(1, k, v);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bit_out(input logic b);
        mosi = b;
        tick(2);
        spi_clk = 1'b0;
        tick(2);
        spi_clk = 1'b1;
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) bit_out(w[i]);
    endtask

    task automatic frame_start();
        cs = 1'b0;
        tick(4);
    endtask

    task automatic frame_end();
        tick(2);
        cs = 1'b1;
        tick(8);
    endtask

    task automatic chk_quiet(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s dut%0d rx_data", tag, d), rx_data[d], 8'h00);
            chk($sformatf("%s dut%0d rx_valid", tag, d), {7'd0, rx_valid[d]}, 8'h00);
            chk($sformatf("%s dut%0d busy", tag, d), {7'd0, busy[d]}, 8'h00);
            chk($sformatf("%s dut%0d frame_err", tag, d), {7'd0, frame_err[d]}, 8'h00);
            chk($sformatf("%s dut%0d overrun", tag, d), {7'd0, overrun[d]}, 8'h00);
        end
    endtask

    initial begin
        logic [7:0] w;
        reset    = 1'b1;
        spi_clk  = 1'b1;
        cs       = 1'b1;
        mosi     = 1'b1;
        rx_ready = 1'b1;
        tick(3);
        chk_quiet("reset");
        reset = 1'b0;
        tick(3);

        // Full 0xA5 frame, cs rises after the 8th bit
        expect_both(K_WORD, 8'hA5);
        frame_start();
        chk("a5 dut0 busy", {7'd0, busy[0]}, 8'h01);
        send_word(8'hA5);
        frame_end();
        chk("a5 dut0 busy after cs", {7'd0, busy[0]}, 8'h00);
        chk("a5 dut1 busy after cs", {7'd0, busy[1]}, 8'h00);

        // Master-style 0x3C: cs rises with the last bit driven, no 8th edge
        expect_ev(0, K_FERR, 8'h00);
        expect_ev(1, K_WORD, 8'h3C);
        w = 8'h3C;
        frame_start();
        for (int i = 7; i >= 1; i--) bit_out(w[i]);
        mosi = w[0];
        cs   = 1'b1;
        tick(8);
        chk("3c dut0 rx_valid", {7'd0, rx_valid[0]}, 8'h00);

        // Abort after 4 bits of 0xF0, then a clean 0x81
        expect_both(K_FERR, 8'h00);
        w = 8'hF0;
        frame_start();
        for (int i = 7; i >= 4; i--) bit_out(w[i]);
        frame_end();
        chk("f0 dut1 rx_valid", {7'd0, rx_valid[1]}, 8'h00);
        expect_both(K_WORD, 8'h81);
        frame_start();
        send_word(8'h81);
        frame_end();

        // Two words with consumer stalled: second word dropped
        rx_ready = 1'b0;
        expect_both(K_OVR, 8'h00);
        expect_both(K_WORD, 8'h12);
        frame_start();
        send_word(8'h12);
        send_word(8'h34);
        frame_end();
        chk("ovr dut0 rx_data", rx_data[0], 8'h12);
        chk("ovr dut1 rx_data", rx_data[1], 8'h12);
        rx_ready = 1'b1;
        tick(3);

        // Two words, consumer accepts exactly on the second completion
        rx_ready = 1'b0;
        expect_both(K_WORD, 8'h12);
        expect_both(K_WORD, 8'h34);
        w = 8'h34;
        frame_start();
        send_word(8'h12);
        for (int i = 7; i >= 1; i--) bit_out(w[i]);
        mosi = w[0];
        tick(2);
        spi_clk = 1'b0;
        tick(2);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        spi_clk  = 1'b1;
        frame_end();
        chk("simul dut0 rx_data", rx_data[0], 8'h34);
        chk("simul dut1 rx_valid", {7'd0, rx_valid[1]}, 8'h01);
        rx_ready = 1'b1;
        tick(3);

        // Reset after 5 bits; master abandons the frame, then sends 0x5A
        frame_start();
        for (int i = 0; i < 5; i++) bit_out(1'b1);
        reset   = 1'b1;
        cs      = 1'b1;
        spi_clk = 1'b1;
        tick(2);
        chk_quiet("midreset");
        reset = 1'b0;
        tick(4);
        expect_both(K_WORD, 8'h5A);
        frame_start();
        send_word(8'h5A);
        frame_end();

        // spi_clk activity with cs high must be ignored
        for (int i = 0; i < 10; i++) begin
            spi_clk = ~spi_clk;
            mosi    = ~mosi;
            tick(2);
        end
        spi_clk = 1'b1;
        tick(4);
        chk("idle dut0 busy", {7'd0, busy[0]}, 8'h00);
        chk("idle dut1 rx_valid", {7'd0, rx_valid[1]}, 8'h00);

        chk("dut0 pending events", 8'(q0.size()), 8'h00);
        chk("dut1 pending events", 8'(q1.size()), 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
